colour_window_filter: RTL

- Parametrised successor to the single-range SW-driven colour filter in the VGA path.
- Sits between D8M_SET RGB output and the VGA controller.
- Classifies each pixel against NUM_WIN independent inclusive RGB windows and rewrites the pixel according to a display mode.
- Accumulates per-window pixel count and bounding box per frame, published at end of frame.

---
 rtl/colour_window_filter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/colour_window_filter.sv
// colour_window_filter: classifies pixels against NUM_WIN RGB windows, rewrites them per display mode, and gathers per-frame window statistics
// Ports: iCLK/iRST clock and sync reset; iVALID/iRed/iGreen/iBlue/iX/iY/iEOF pixel stream in;
//   iMODE/iWIN_EN/i*_MIN/i*_MAX config shadowed on iEOF; iHL_* live highlight colour;
//   oVALID/oRed/oGreen/oBlue/oMATCH pixel stream out (2-cycle latency);
//   oSTAT_VALID/oCOUNT/oXMIN/oXMAX/oYMIN/oYMAX per-window frame statistics.
module colour_window_filter #(
  parameter int DATA_W  = 8,
  parameter int NUM_WIN = 4,
  parameter int XY_W    = 16,
  parameter int CNT_W   = 20
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iVALID,
  input  logic [DATA_W-1:0]         iRed,
  input  logic [DATA_W-1:0]         iGreen,
  input  logic [DATA_W-1:0]         iBlue,
  input  logic [XY_W-1:0]           iX,
  input  logic [XY_W-1:0]           iY,
  input  logic                      iEOF,
  input  logic [1:0]                iMODE,
  input  logic [NUM_WIN-1:0]        iWIN_EN,
  input  logic [NUM_WIN*DATA_W-1:0] iR_MIN,
  input  logic [NUM_WIN*DATA_W-1:0] iR_MAX,
  input  logic [NUM_WIN*DATA_W-1:0] iG_MIN,
  input  logic [NUM_WIN*DATA_W-1:0] iG_MAX,
  input  logic [NUM_WIN*DATA_W-1:0] iB_MIN,
  input  logic [NUM_WIN*DATA_W-1:0] iB_MAX,
  input  logic [DATA_W-1:0]         iHL_R,
  input  logic [DATA_W-1:0]         iHL_G,
  input  logic [DATA_W-1:0]         iHL_B,
  output logic                      oVALID,
  output logic [DATA_W-1:0]         oRed,
  output logic [DATA_W-1:0]         oGreen,
  output logic [DATA_W-1:0]         oBlue,
  output logic [NUM_WIN-1:0]        oMATCH,
  output logic                      oSTAT_VALID,
  output logic [NUM_WIN*CNT_W-1:0]  oCOUNT,
  output logic [NUM_WIN*XY_W-1:0]   oXMIN,
  output logic [NUM_WIN*XY_W-1:0]   oXMAX,
  output logic [NUM_WIN*XY_W-1:0]   oYMIN,
  output logic [NUM_WIN*XY_W-1:0]   oYMAX
);
  logic [NUM_WIN-1:0]        sh_en;
  logic [NUM_WIN*DATA_W-1:0] sh_rmin, sh_rmax, sh_gmin, sh_gmax, sh_bmin, sh_bmax;
  logic [1:0]                sh_mode;
  logic [NUM_WIN-1:0]        match;
  logic                      s1_valid, s1_eof;
  logic [DATA_W-1:0]         s1_r, s1_g, s1_b;
  logic [XY_W-1:0]           s1_x, s1_y;
  logic [NUM_WIN-1:0]        s1_match;
  logic [1:0]                s1_mode;
  logic                      any;
  logic [DATA_W+1:0]         grey_sum;
  logic [DATA_W-1:0]         grey;
  logic [3*DATA_W-1:0]       pass, pix_out;
  logic [NUM_WIN-1:0][CNT_W-1:0] acc_cnt, cnt_n, st_cnt;
  logic [NUM_WIN-1:0][XY_W-1:0]  acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [NUM_WIN-1:0][XY_W-1:0]  xmin_n, xmax_n, ymin_n, ymax_n;
  logic [NUM_WIN-1:0][XY_W-1:0]  st_xmin, st_xmax, st_ymin, st_ymax;
  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    assign match[w] = sh_en[w] &&
      iRed   >= sh_rmin[w*DATA_W +: DATA_W] && iRed   <= sh_rmax[w*DATA_W +: DATA_W] &&
      iGreen >= sh_gmin[w*DATA_W +: DATA_W] && iGreen <= sh_gmax[w*DATA_W +: DATA_W] &&
      iBlue  >= sh_bmin[w*DATA_W +: DATA_W] && iBlue  <= sh_bmax[w*DATA_W +: DATA_W];
  end
  assign any      = |s1_match;
  assign grey_sum = {2'b0, s1_r} + {1'b0, s1_g, 1'b0} + {2'b0, s1_b};
  assign grey     = grey_sum[DATA_W+1:2];
  assign pass     = {s1_r, s1_g, s1_b};
  assign pix_out  = s1_mode == 2'd1 ? (any ? {iHL_R, iHL_G, iHL_B} : pass) :
                    s1_mode == 2'd2 ? (any ? pass : '0) :
                    s1_mode == 2'd3 ? (any ? pass : {3{grey}}) : pass;
  always_comb begin
    cnt_n  = acc_cnt;
    xmin_n = acc_xmin;
    xmax_n = acc_xmax;
    ymin_n = acc_ymin;
    ymax_n = acc_ymax;
    for (int i = 0; i < NUM_WIN; i++)
      if (s1_valid && s1_match[i]) begin
        cnt_n[i]  = &acc_cnt[i] ? acc_cnt[i] : acc_cnt[i] + CNT_W'(1);
        xmin_n[i] = s1_x < acc_xmin[i] ? s1_x : acc_xmin[i];
        xmax_n[i] = s1_x > acc_xmax[i] ? s1_x : acc_xmax[i];
        ymin_n[i] = s1_y < acc_ymin[i] ? s1_y : acc_ymin[i];
        ymax_n[i] = s1_y > acc_ymax[i] ? s1_y : acc_ymax[i];
      end
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sh_en       <= '0;
      sh_rmin     <= '0;
      sh_rmax     <= '0;
      sh_gmin     <= '0;
      sh_gmax     <= '0;
      sh_bmin     <= '0;
      sh_bmax     <= '0;
      sh_mode     <= '0;
      s1_valid    <= 1'b0;
      s1_eof      <= 1'b0;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_match    <= '0;
      s1_mode     <= '0;
      oVALID      <= 1'b0;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oMATCH      <= '0;
      oSTAT_VALID <= 1'b0;
      acc_cnt     <= '0;
      acc_xmin    <= '1;
      acc_xmax    <= '0;
      acc_ymin    <= '1;
      acc_ymax    <= '0;
      st_cnt      <= '0;
      st_xmin     <= '0;
      st_xmax     <= '0;
      st_ymin     <= '0;
      st_ymax     <= '0;
    end else begin
      if (iEOF) begin
        sh_en   <= iWIN_EN;
        sh_rmin <= iR_MIN;
        sh_rmax <= iR_MAX;
        sh_gmin <= iG_MIN;
        sh_gmax <= iG_MAX;
        sh_bmin <= iB_MIN;
        sh_bmax <= iB_MAX;
        sh_mode <= iMODE;
      end
      s1_valid    <= iVALID;
      s1_eof      <= iEOF;
      s1_r        <= iRed;
      s1_g        <= iGreen;
      s1_b        <= iBlue;
      s1_x        <= iX;
      s1_y        <= iY;
      s1_match    <= match;
      s1_mode     <= sh_mode;
      oVALID      <= s1_valid;
      oSTAT_VALID <= s1_eof;
      if (s1_valid) begin
        {oRed, oGreen, oBlue} <= pix_out;
        oMATCH                <= s1_match;
      end
      // The EOF pixel is folded into the published stats; accumulators restart empty.
      if (s1_eof) begin
        st_cnt   <= cnt_n;
        st_xmin  <= xmin_n;
        st_xmax  <= xmax_n;
        st_ymin  <= ymin_n;
        st_ymax  <= ymax_n;
        acc_cnt  <= '0;
        acc_xmin <= '1;
        acc_xmax <= '0;
        acc_ymin <= '1;
        acc_ymax <= '0;
      end else begin
        acc_cnt  <= cnt_n;
        acc_xmin <= xmin_n;
        acc_xmax <= xmax_n;
        acc_ymin <= ymin_n;
        acc_ymax <= ymax_n;
      end
    end
  end
  assign oCOUNT = st_cnt;
  assign oXMIN  = st_xmin;
  assign oXMAX  = st_xmax;
  assign oYMIN  = st_ymin;
  assign oYMAX  = st_ymax;
endmodule
